// File: rtl/mio_ps2_pkg.sv
// ============================================================================
//  Module   : mio_ps2_pkg
//  Purpose  : Shared PS/2 constants, state encoding and helpers for the MIO
//             PS/2 transmit and receive paths.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mio_ps2_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_INHIBIT   = 3'd1;
    localparam state_t ST_START     = 3'd2;
    localparam state_t ST_SEND      = 3'd3;
    localparam state_t ST_ACK       = 3'd4;
    localparam state_t ST_WAIT_IDLE = 3'd5;

    localparam int         PS2_FRAME_FALLS = 11;
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

    // Width of a counter that must reach max(a, b) - 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mio_ps2_sync.sv
// ============================================================================
//  Module   : mio_ps2_sync
//  Purpose  : 2-FF synchroniser with fall/rise detect for one PS/2 line.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mio_ps2_sync (
    input  logic clk,
    input  logic clrn,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall,
    output logic o_rise
);

    logic [1:0] r_sync;

    // Reset to the idle-high line level so leaving reset never looks like a fall.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_line};
        end
    end

    assign o_sync = r_sync[1];
    assign o_fall = r_sync[1] & ~r_sync[0];
    assign o_rise = ~r_sync[1] & r_sync[0];

endmodule

`default_nettype wire

// File: rtl/mio_ps2_tx.sv
// ============================================================================
//  Module   : mio_ps2_tx
//  Purpose  : Host-to-device PS/2 command transmitter with open-collector
//             pull-low enables and busy/done/ack_err/timeout status.
//             Optional watchdog enabled by macro MIO_PS2_TX_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mio_ps2_tx
    import mio_ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       wrn,
    input  logic [7:0] din,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    // One counter serves the inhibit delay and, when enabled, the watchdog.
    localparam int                 c_CNT_W        = cnt_width(INHIBIT_CYCLES, TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_INHIBIT_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
`ifdef MIO_PS2_TX_TIMEOUT_EN
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
`endif
    localparam logic [3:0]         c_STOP_FALL    = 4'(PS2_FRAME_FALLS - 2);

    state_t             r_state;
    logic [3:0]         r_bitcnt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [8:0]         r_frame;
    logic               r_clk_oe;
    logic               r_data_oe;
    logic               r_busy;
    logic               r_done;
    logic               r_ack_err;
`ifdef MIO_PS2_TX_TIMEOUT_EN
    logic               r_timeout;
`endif

    logic w_clk_s;
    logic w_clk_fall;
    logic w_clk_rise;
    logic w_data_s;
    logic w_data_fall;
    logic w_data_rise;
    logic w_unused;

    mio_ps2_sync u_sync_clk (
        .clk    (clk),
        .clrn   (clrn),
        .i_line (ps2_clk),
        .o_sync (w_clk_s),
        .o_fall (w_clk_fall),
        .o_rise (w_clk_rise)
    );

    mio_ps2_sync u_sync_data (
        .clk    (clk),
        .clrn   (clrn),
        .i_line (ps2_data),
        .o_sync (w_data_s),
        .o_fall (w_data_fall),
        .o_rise (w_data_rise)
    );

    // Edge outputs only the receive path needs.
    assign w_unused = w_clk_rise & w_data_fall & w_data_rise;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state   <= ST_IDLE;
            r_bitcnt  <= 4'd0;
            r_cnt     <= '0;
            r_frame   <= 9'd0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
`ifdef MIO_PS2_TX_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!wrn) begin
                        r_frame   <= {~^din, din};
                        r_ack_err <= 1'b0;
`ifdef MIO_PS2_TX_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                        r_cnt     <= '0;
                        r_clk_oe  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (r_cnt == c_INHIBIT_LAST) begin
                        r_data_oe <= 1'b1;
                        r_state   <= ST_START;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_START: begin
                    r_clk_oe <= 1'b0;
                    r_cnt    <= '0;
                    r_bitcnt <= 4'd0;
                    r_state  <= ST_SEND;
                end
                // Start bit stays driven until the first fall; each fall presents the next bit.
                ST_SEND: begin
                    if (w_clk_fall) begin
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == c_STOP_FALL) begin
                            r_data_oe <= 1'b0;
                            r_state   <= ST_ACK;
                        end else begin
                            r_data_oe <= ~r_frame[r_bitcnt];
                        end
                    end
                end
                ST_ACK: begin
                    if (w_clk_fall) begin
                        r_ack_err <= w_data_s;
                        r_state   <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_clk_s && w_data_s) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
`ifdef MIO_PS2_TX_TIMEOUT_EN
            // Watchdog overrides whatever the device-clocked states decided.
            if (r_state == ST_SEND || r_state == ST_ACK || r_state == ST_WAIT_IDLE) begin
                if (r_cnt == c_TIMEOUT_LAST) begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_timeout <= 1'b1;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
`endif
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign ack_err     = r_ack_err;
`ifdef MIO_PS2_TX_TIMEOUT_EN
    assign timeout     = r_timeout;
`else
    assign timeout     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mio_ps2_tx.sv
// ============================================================================
//  Module   : tb_mio_ps2_tx
//  Purpose  : Self-checking bench for mio_ps2_tx with a PS/2 device model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mio_ps2_tx;
    import mio_ps2_pkg::*;

    localparam int c_INH = 40;
    localparam int c_TMO = 3000;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       wrn = 1'b1;
    logic [7:0] din = 8'd0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_l;
    logic       ps2_data_l;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout;

    int n_cmp = 0;
    int n_fail = 0;

    // Open-collector bus: either side may pull low.
    assign ps2_clk_l  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_l = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    mio_ps2_tx #(
        .INHIBIT_CYCLES (c_INH),
        .TIMEOUT_CYCLES (c_TMO)
    ) u_dut (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk     (ps2_clk_l),
        .ps2_data    (ps2_data_l),
        .wrn         (wrn),
        .din         (din),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected line sequence: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        int ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = (ones % 2 == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic write_byte(input logic [7:0] b);
        din = b;
        wrn = 1'b0;
        tick(1);
        wrn = 1'b1;
        din = 8'($urandom);
        check("wr_busy", busy, 1);
        check("wr_latency_clk_oe", {ps2_clk_oe, ps2_data_oe}, 2'b10);
    endtask

    task automatic check_inhibit();
        int n;
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < c_INH + 10) begin
            n++;
            tick(1);
        end
        check("inhibit_len", n, c_INH);
        check("start_cycle", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        tick(1);
        check("send_entry", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    endtask

    task automatic device_frame(input int half, input bit give_ack, input int inject_after,
                                input int abort_after, output logic [10:0] got);
        int w;
        got = '0;
        w = 0;
        while (!(ps2_clk_l && !ps2_data_l) && w < 50) begin
            tick(1);
            w++;
        end
        check("rts_seen", (w < 50), 1);
        got[0] = ps2_data_l;
        tick(half);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            tick(half);
            dev_clk_low = 1'b0;
            tick(1);
            got[i] = ps2_data_l;
            if (i == 10) check("stop_released", ps2_data_oe, 0);
            if (i == inject_after) begin
                din = 8'hAA;
                wrn = 1'b0;
                tick(1);
                wrn = 1'b1;
                check("ignored_wr_busy", busy, 1);
            end
            if (i == abort_after) begin
                clrn = 1'b0;
                tick(1);
                check("abort_release", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
                clrn = 1'b1;
                return;
            end
            tick(half - 1);
        end
        if (give_ack) dev_data_low = 1'b1;
        tick(2);
        dev_clk_low = 1'b1;
        tick(half);
        dev_clk_low = 1'b0;
        tick(2);
        dev_data_low = 1'b0;
    endtask

    // Runs one frame; leaves the bench on the cycle done is observed.
    task automatic xfer(input logic [7:0] b, input bit give_ack, input int inject_after,
                        input bit already_written);
        logic [10:0] got;
        int k;
        if (!already_written) write_byte(b);
        check_inhibit();
        device_frame(int'($urandom_range(15, 30)), give_ack, inject_after, 0, got);
        check("frame_bits", got, ref_frame(b));
        k = 0;
        while (!done && k < 300) begin
            tick(1);
            k++;
        end
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
        check("ack_err", ack_err, !give_ack);
        check("lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    endtask

    task automatic close_done();
        tick(1);
        check("done_one_shot", done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  b;
        logic [10:0] got;
        int          n;
        int          pulses;

        tick(3);
        check("reset_outputs", {ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout}, 6'd0);
        clrn = 1'b1;
        tick(5);
        check("idle_quiet", {ps2_clk_oe, ps2_data_oe, busy, done}, 4'd0);

        xfer(PS2_CMD_SET_LED, 1'b1, 0, 1'b0);
        close_done();

        xfer(8'h00, 1'b1, 0, 1'b0);
        close_done();
        xfer(8'h01, 1'b1, 0, 1'b0);
        close_done();
        xfer(PS2_CMD_RESET, 1'b1, 0, 1'b0);
        close_done();

        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            xfer(b, 1'b1, 0, 1'b0);
            close_done();
        end

        // Device withholds the ACK.
        xfer(8'($urandom), 1'b0, 0, 1'b0);
        close_done();
        check("ack_err_sticky", ack_err, 1);
        write_byte(8'hF4);
        check("ack_err_cleared", ack_err, 0);
        xfer(8'hF4, 1'b1, 0, 1'b1);
        close_done();

        // Write while busy is ignored; then back-to-back write on the done cycle.
        xfer(8'h3C, 1'b1, 3, 1'b0);
        din = 8'h5A;
        wrn = 1'b0;
        tick(1);
        wrn = 1'b1;
        check("b2b_done_low", done, 0);
        check("b2b_accepted", {busy, ps2_clk_oe}, 2'b11);
        xfer(8'h5A, 1'b1, 0, 1'b1);
        close_done();

        // Reset in the middle of SEND.
        write_byte(PS2_CMD_SET_LED);
        check_inhibit();
        device_frame(20, 1'b1, 0, 4, got);
        tick(3);
        check("post_abort_idle", {ps2_clk_oe, ps2_data_oe, busy, done}, 4'd0);
        xfer(PS2_CMD_SET_LED, 1'b1, 0, 1'b0);
        close_done();

        // Silent device.
        write_byte(8'($urandom));
        check_inhibit();
`ifdef MIO_PS2_TX_TIMEOUT_EN
        n = 0;
        while (!done && n < c_TMO + 50) begin
            n++;
            tick(1);
        end
        check("tmo_len", n, c_TMO);
        check("tmo_done", done, 1);
        check("tmo_flag", timeout, 1);
        check("tmo_released", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
        close_done();
        check("tmo_sticky", timeout, 1);
        write_byte(8'h12);
        check("tmo_cleared", timeout, 0);
        pulses = 0;
`else
        pulses = 0;
        for (int i = 0; i < c_TMO + 100; i++) begin
            tick(1);
            if (done) pulses++;
        end
        check("silent_no_done", pulses, 0);
        check("silent_busy", busy, 1);
        check("silent_timeout", timeout, 0);
`endif
        clrn = 1'b0;
        tick(1);
        clrn = 1'b1;
        tick(2);
        check("final_idle", {ps2_clk_oe, ps2_data_oe, busy, timeout}, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
